// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: TX state encoding, frame size, odd parity and common
// keyboard command bytes. Used by the host transmitter and the receive side.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake bundle of the PS/2 host transmitter.
// master = command source, slave = transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid, tx_byte,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_valid, tx_byte,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins plus a registered
// falling-edge pulse on the clock; the pulse lands 3 cycles after the pin edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_pin,
  input  logic ps2_data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] pin;
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  assign pin = {ps2_data_pin, ps2_clk_pin};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      assign meta_d[gi] = pin[gi];
      assign sync_d[gi] = meta_q[gi];
    end
  endgenerate

  always_comb begin
    clk_prev_d = sync_q[0];
    fall_d     = clk_prev_q & ~sync_q[0];
  end

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
    end
  end

  assign clk_sync  = sync_q[0];
  assign data_sync = sync_q[1];
  assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 11-bit frame, ACK check).
// Optional watchdog from REQUEST to ACK: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          PS2_clk,
  input  logic          PS2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int INH_W          = $clog2(INHIBIT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);

  // Bits shifted out on device clock edges: 8 data, parity, stop.
  localparam int SHIFT_BITS = PS2_FRAME_BITS - 1;
  localparam int IDX_W      = $clog2(SHIFT_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SHIFT_BITS - 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W           = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  logic clk_sync, data_sync, clk_fall;

  ps2_line_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_pin  (PS2_clk),
    .ps2_data_pin (PS2_data_in),
    .clk_sync     (clk_sync),
    .data_sync    (data_sync),
    .clk_fall     (clk_fall)
  );

  ps2_tx_state_t          state_q, state_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SHIFT_BITS-1:0]  frame_q, frame_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   tx_error_q, tx_error_d;

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_ready_d = tx_ready_q;
    busy_d     = busy_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (bus.tx_valid && tx_ready_q) begin
          frame_d    = {1'b1, ps2_odd_parity(bus.tx_byte), bus.tx_byte};
          inh_cnt_d  = '0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = REQUEST;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          // Start bit goes out on the final inhibit cycle.
          if (inh_cnt_q == INH_DATA) data_oe_d = 1'b1;
        end
      end
      REQUEST: begin
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[SHIFT_BITS-1:1]};
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (data_sync) tx_error_d = 1'b1;
          else           tx_done_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_sync && data_sync) begin
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides everything, including an ACK landing on the same cycle.
    wd_d = '0;
    if (state_q inside {REQUEST, SHIFT, ACK}) begin
      if (wd_q == WD_LAST) begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b1;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_error = tx_error_q;
  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
// Timeout case runs only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT_CYCLES = 10_000;  // 100 MHz * 100 us
  localparam int TIMEOUT_CYCLES = 10_000;  // 100 MHz * 100 us (bench override)
  localparam int HALF           = 25;      // device clock half period in sys cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_line, ps2_data_line;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_line  = ~(dev_clk_low  | ps2_clk_oe);
  assign ps2_data_line = ~(dev_data_low | ps2_data_oe);

  ps2_host_tx #(
    .CLK_FREQ_HZ (100_000_000),
    .INHIBIT_US  (100),
    .TIMEOUT_US  (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .PS2_clk     (ps2_clk_line),
    .PS2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, accept_cnt = 0, ready_busy_cnt = 0;

  always @(negedge clk) begin
    if (bus.tx_done)                  done_cnt       <= done_cnt + 1;
    if (bus.tx_error)                 err_cnt        <= err_cnt + 1;
    if (bus.tx_done && bus.tx_error)  both_cnt       <= both_cnt + 1;
    if (bus.tx_valid && bus.tx_ready) accept_cnt     <= accept_cnt + 1;
    if (bus.tx_ready && bus.busy)     ready_busy_cnt <= ready_busy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a byte at a negedge; the handshake happens on the following posedge.
  task automatic start_xfer(input logic [7:0] b, input bit hold);
    int t = 0;
    @(negedge clk);
    while (!bus.tx_ready && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check_eq("ready_before_xfer", 32'(t < 30000), 1);
    bus.tx_valid = 1'b1;
    bus.tx_byte  = b;
    @(posedge clk);
    #1;
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Device: waits for the request, then generates n_edges clocks, sampling on rising edges.
  task automatic dev_run(input int n_edges, input bit ack, output logic [9:0] rx);
    int t = 0;
    rx = '0;
    @(negedge clk);
    while (!(bus.busy && !ps2_clk_oe && ps2_data_oe) && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check_eq("request_seen", 32'(t < 30000), 1);
    repeat (HALF) @(negedge clk);
    check_eq("start_bit", 32'(ps2_data_line), 0);
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) rx[i-1] = ps2_data_line;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (bus.busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 32'(t < 2000), 1);
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input bit ack,
                          input logic [9:0] exp_rx, input bit measure, input bit hold);
    int d0, e0, a0, n_clk, n_both;
    logic [9:0] rx;
    d0 = done_cnt; e0 = err_cnt; a0 = accept_cnt;
    start_xfer(b, hold);
    if (measure) begin
      n_clk = 0; n_both = 0;
      @(negedge clk);
      check_eq({tag, "_busy_n1"}, 32'(bus.busy), 1);
      while (ps2_clk_oe && n_clk < 30000) begin
        n_clk++;
        if (ps2_data_oe) n_both++;
        @(negedge clk);
      end
      check_eq({tag, "_inhibit_cycles"}, 32'(n_clk), INHIBIT_CYCLES);
      check_eq({tag, "_start_overlap"}, 32'(n_both), 1);
    end
    dev_run(11, ack, rx);
    if (hold) bus.tx_valid = 1'b0;
    wait_idle({tag, "_idle"});
    repeat (2) @(negedge clk);
    check_eq({tag, "_frame"}, 32'(rx), 32'(exp_rx));
    check_eq({tag, "_done"}, 32'(done_cnt - d0), ack ? 1 : 0);
    check_eq({tag, "_error"}, 32'(err_cnt - e0), ack ? 0 : 1);
    check_eq({tag, "_accepts"}, 32'(accept_cnt - a0), 1);
    check_eq({tag, "_ready"}, 32'(bus.tx_ready), 1);
    $display("xfer %s byte=%02h ack=%0d frame=%03h done=%0d err=%0d", tag, b, ack, rx,
             done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    logic [9:0] rx;
    int d0, e0, k;
    bus.tx_valid = 1'b0;
    bus.tx_byte  = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready",   32'(bus.tx_ready), 1);
    check_eq("rst_busy",    32'(bus.busy), 0);
    check_eq("rst_clk_oe",  32'(ps2_clk_oe), 0);
    check_eq("rst_data_oe", 32'(ps2_data_oe), 0);
    check_eq("rst_done",    32'(bus.tx_done), 0);
    check_eq("rst_error",   32'(bus.tx_error), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("reset released");

    // 0xED: data 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1
    run_xfer("ed_ack", PS2_CMD_SET_LEDS, 1'b1, 10'h3ED, 1'b1, 1'b0);
    run_xfer("00_ack", 8'h00, 1'b1, 10'h300, 1'b0, 1'b0);
    // 0x01: parity 0; device leaves data high on edge 11
    run_xfer("01_nack", 8'h01, 1'b0, 10'h201, 1'b0, 1'b0);

    // Bus edges while idle must be ignored.
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk); dev_clk_low = 1'b0;
    end
    repeat (5) @(negedge clk);
    check_eq("idle_edges_busy",  32'(bus.busy), 0);
    check_eq("idle_edges_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    check_eq("idle_edges_oe",    32'({ps2_clk_oe, ps2_data_oe}), 0);
    $display("idle edges ignored: busy=%0d", bus.busy);

    // Reset after data bit 3.
    start_xfer(8'hED, 1'b0);
    dev_run(3, 1'b0, rx);
    check_eq("rst_mid_bits", 32'(rx[2:0]), 32'(3'b101));
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ready",   32'(bus.tx_ready), 1);
    check_eq("rst_mid_busy",    32'(bus.busy), 0);
    check_eq("rst_mid_oe",      32'({ps2_clk_oe, ps2_data_oe}), 0);
    check_eq("rst_mid_pulse",   32'({bus.tx_done, bus.tx_error}), 0);
    rst = 1'b0;
    $display("reset mid-transfer: ready=%0d busy=%0d", bus.tx_ready, bus.busy);
    repeat (HALF) @(negedge clk);

    // 0xFF with tx_valid held high through the transfer: parity 1.
    run_xfer("ff_hold", PS2_CMD_RESET, 1'b1, 10'h3FF, 1'b0, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
    // Device never clocks: error after TIMEOUT_CYCLES from REQUEST entry.
    e0 = err_cnt;
    start_xfer(8'h01, 1'b0);
    k = 0;
    @(negedge clk);
    while (ps2_clk_oe && k < 30000) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!bus.tx_error && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check_eq("timeout_cycles",  32'(k), TIMEOUT_CYCLES);
    check_eq("timeout_oe",      32'({ps2_clk_oe, ps2_data_oe}), 0);
    check_eq("timeout_no_done", 32'(bus.tx_done), 0);
    @(negedge clk);
    check_eq("timeout_error_cnt", 32'(err_cnt - e0), 1);
    check_eq("timeout_ready",     32'(bus.tx_ready), 1);
    $display("timeout: cycles=%0d", k);
`endif

    repeat (2) @(negedge clk);
    check_eq("never_done_and_error", 32'(both_cnt), 0);
    check_eq("never_ready_while_busy", 32'(ready_busy_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard using the PS/2 request-to-send sequence. Drives the PS/2 clock and data lines open-drain, then shifts out 8 data bits, odd parity and stop bit on device-generated clock edges, and checks the device ACK bit. It is the return path next to the PS/2 receive capture block, which must ignore the bus while `busy` is high.

## Interface
- `CLK_FREQ_HZ`, 100_000_000, system clock frequency
- `INHIBIT_US`, 100, clock-inhibit time before the request (≥100 µs per PS/2)
- `TIMEOUT_US`, 15000, watchdog limit from request to ACK (only with the timeout feature)
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: a command byte is offered.
- `tx_byte` in 8: the command byte, sampled on the handshake cycle.
- `tx_ready` out 1: high only in IDLE.
- `PS2_clk` in 1: raw PS/2 clock pin level (asynchronous).
- `PS2_data_in` in 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` out 1: 1 drives the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 drives the data line low; 0 releases it.
- `busy` out 1: high in every state except IDLE.
- `tx_done` out 1: one-cycle pulse when ACK is received.
- `tx_error` out 1: one-cycle pulse on NACK or timeout.

## Operation
- States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
- **Handshake:** a transfer is accepted when `tx_valid && tx_ready`. On that cycle the block latches the frame {stop=1, parity, tx_byte}. Parity is odd: parity = ~^tx_byte. `tx_valid` is ignored while `busy` is high.
- **IDLE:** both oe signals 0, `tx_ready` 1.
- **INHIBIT:** `ps2_clk_oe` is 1 for INHIBIT_CYCLES = CLK_FREQ_HZ/1_000_000*INHIBIT_US cycles. On the last cycle `ps2_data_oe` goes to 1 (start bit 0).
- **REQUEST:** `ps2_clk_oe` 0 and `ps2_data_oe` 1. Go to SHIFT with bit index 0.
- **SHIFT:** on each synchronized falling edge of the PS/2 clock, set `ps2_data_oe = ~frame[idx]` and increment idx.
  - Falling edges 1–8 output data bits, LSB first.
  - Edge 9 outputs parity.
  - Edge 10 outputs the stop bit, so data is released.
  - After edge 10, go to ACK.
- **ACK:** on falling edge 11, sample the synchronized data line.
  - Data 0 means ACK: `tx_done` pulses.
  - Data 1 means NACK: `tx_error` pulses.
  - Either way, go to WAIT_IDLE.
- **WAIT_IDLE:** wait until the synchronized clock and data are both 1, then go to IDLE.
- **Boundary conditions:**
  - A reset mid-transfer returns to IDLE, releases both lines and produces no pulse.
  - Bus edges seen while in IDLE are ignored.
  - `tx_done` and `tx_error` never assert on the same cycle.
  - The bit index never exceeds 10.

## Timing
- Reset values: `tx_ready`=1, `busy`=0, `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_done`=0, `tx_error`=0.
- If the handshake occurs in cycle N:
  - `busy`=1 and `ps2_clk_oe`=1 from cycle N+1.
  - `ps2_data_oe`=1 from cycle N+INHIBIT_CYCLES.
  - `ps2_clk_oe`=0 from cycle N+INHIBIT_CYCLES+1.
- Input synchronization is 2 flops followed by an edge register. The falling-edge pulse therefore lands 3 cycles after the pin edge, and `ps2_data_oe` updates 1 cycle after that pulse.
- `tx_done`/`tx_error` are registered and assert 1 cycle after the 11th falling-edge pulse.
- The earliest next acceptance is the first cycle after WAIT_IDLE sees the bus idle.
- All counters are sized with $clog2 of the maximum count and are unsigned. Cycle counts round down.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A watchdog counts from entry to REQUEST.
  - If TIMEOUT_CYCLES = CLK_FREQ_HZ/1_000_000*TIMEOUT_US elapse before ACK completes, both lines are released, `tx_error` pulses and the FSM returns to IDLE directly.
- `PS2_TX_TIMEOUT_EN` undefined:
  - There is no watchdog and the block waits indefinitely for device edges.
  - `tx_error` asserts only on NACK.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum `ps2_tx_state_t`;
  - the frame bit-count constant `PS2_FRAME_BITS = 11`;
  - the odd-parity function;
  - command constants `PS2_CMD_SET_LEDS = 8'hED` and `PS2_CMD_RESET = 8'hFF`.
- One sub-module: `ps2_line_sync`. It contains the 2-flop synchronizers for clock and data plus the falling-edge pulse generator, and is reusable by the receive side.

## Test plan
- **Send 0xED with ACK:** the device model samples on rising edges and receives bits 1,0,1,1,0,1,1,1, parity 1 (six ones, so odd parity adds 1), stop 1. Pulling data low on edge 11 gives exactly one `tx_done` pulse, and `busy` falls after the bus idles.
- **Send 0x00:** the parity bit is 1. Send 0x01: the parity bit is 0.
- **NACK:** the device leaves data high on edge 11, giving one `tx_error` pulse, no `tx_done`, and a return to IDLE.
- **Timeout (`PS2_TX_TIMEOUT_EN` defined):** the device never clocks. After TIMEOUT_CYCLES `tx_error` pulses and both oe signals are 0.
- **Reset after data bit 3:** the next cycle shows IDLE with both oe signals 0 and no pulse. A fresh 0xFF transfer then completes normally.
- **`tx_valid` held high through a transfer:** exactly one transfer runs per acceptance. `inhibit` is measured at INHIBIT_CYCLES (10_000 at default parameters).
